// File: rtl/axi_resp_pkg.sv
// Shared types and widths for the AXI memory responder.
//
// Contents:
//   rd_state_e   - read path FSM states
//   wr_state_e   - write path FSM states
//   AXI_DW/AW/SW - data, address and strobe widths
//   strb_merge   - byte-strobed merge of new data into an existing word
package axi_resp_pkg;

    localparam int AXI_DW = 64;
    localparam int AXI_AW = 64;
    localparam int AXI_SW = 8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Replace each byte of old_word whose strobe bit is set with the new byte.
    function automatic logic [AXI_DW-1:0] strb_merge(
        input logic [AXI_DW-1:0] old_word,
        input logic [AXI_DW-1:0] new_word,
        input logic [AXI_SW-1:0] strb
    );
        logic [AXI_DW-1:0] res;
        res = old_word;
        for (int i = 0; i < AXI_SW; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_resp_mem.sv
// Doubleword memory behind the AXI responder.
//
// Ports:
//   clk_i       clock
//   rd_idx_i    word index for the asynchronous read port
//   rd_data_o   word at rd_idx_i (combinational)
//   we_i        write enable, sampled at the rising edge
//   wr_idx_i    word index for the write port
//   wr_data_i   write data
//   wr_strb_i   byte enables; bit i selects wr_data_i[8i+7:8i]
//
// Contents are not reset. Any preloading of u_mem.mem_q is left to the
// simulation top so that this file stays purely synthesizable.
module axi_resp_mem
    import axi_resp_pkg::*;
#(
    parameter int MEM_DEPTH = 4096,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [AXI_DW-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [AXI_DW-1:0] wr_data_i,
    input  logic [AXI_SW-1:0] wr_strb_i
);

    logic [AXI_DW-1:0] mem_q [MEM_DEPTH];

    assign rd_data_o = mem_q[rd_idx_i];

    // Byte-strobed synchronous write; a same-edge read sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= strb_merge(mem_q[wr_idx_i], wr_data_i, wr_strb_i);
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-Lite-style memory responder (no RESP/ID/LEN) for 64-bit master ports.
// Independent read (AR/R) and write (AW/W/B) FSMs, one outstanding each.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   axi_AW_ADDR/VALID/READY         write address channel
//   axi_W_DATA/STRB/VALID/READY     write data channel
//   axi_B_VALID/READY               write response channel
//   axi_AR_ADDR/VALID/READY         read address channel
//   axi_R_DATA/VALID/READY          read data channel
//
// Build option: define AXI_RESP_RAND_DELAY_EN to add 0..3 LFSR-driven extra
// latency cycles per transaction and random AR/AW ready hold-off.
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter logic [AXI_AW-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int                MEM_DEPTH  = 4096,
    parameter int                RD_LATENCY = 1,
    parameter int                WR_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AXI_AW-1:0] axi_AW_ADDR,
    input  logic              axi_AW_VALID,
    output logic              axi_AW_READY,
    input  logic [AXI_DW-1:0] axi_W_DATA,
    input  logic [AXI_SW-1:0] axi_W_STRB,
    input  logic              axi_W_VALID,
    output logic              axi_W_READY,
    output logic              axi_B_VALID,
    input  logic              axi_B_READY,
    input  logic [AXI_AW-1:0] axi_AR_ADDR,
    input  logic              axi_AR_VALID,
    output logic              axi_AR_READY,
    output logic [AXI_DW-1:0] axi_R_DATA,
    output logic              axi_R_VALID,
    input  logic              axi_R_READY
);

    localparam int                IDX_W     = $clog2(MEM_DEPTH);
    localparam int                CNT_W     = 8;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AXI_AW-1:0] MEM_BYTES = AXI_AW'(MEM_DEPTH) << 3;

    // Extra latency and ready hold-off, both zero in the fixed-latency build.
    logic [CNT_W-1:0] extra_s;
    logic             hold_off_s;

`ifdef AXI_RESP_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, shifting every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign extra_s    = {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
    // Ready registers are computed one cycle ahead, so the mask looks at the
    // next LFSR value: READY is 0 exactly in cycles where lfsr_q[7] = 1.
    assign hold_off_s = lfsr_d[7];
`else
    assign extra_s    = CNT_ZERO;
    assign hold_off_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [AXI_AW-1:0] rd_addr_q, rd_addr_d;
    logic [AXI_DW-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              ar_ready_q, ar_ready_d;

    logic [AXI_AW-1:0] rd_off_s;
    logic              rd_in_range_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [AXI_DW-1:0] mem_rd_data_s;

    // Offset check done on the difference so a top-of-memory limit cannot wrap.
    assign rd_off_s      = rd_addr_q - BASE_ADDR;
    assign rd_in_range_s = (rd_addr_q >= BASE_ADDR) && (rd_off_s < MEM_BYTES);
    assign rd_idx_s      = rd_off_s[IDX_W+2:3];

    // Read FSM next-state and registered-output logic.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        r_data_d   = r_data_q;
        r_valid_d  = r_valid_q;
        ar_ready_d = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (axi_AR_VALID && ar_ready_q) begin
                    rd_state_d = R_WAIT;
                    rd_addr_d  = axi_AR_ADDR;
                    rd_cnt_d   = CNT_W'(RD_LATENCY) + extra_s;
                end else begin
                    ar_ready_d = !hold_off_s;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == CNT_ZERO) begin
                    r_data_d   = rd_in_range_s ? mem_rd_data_s : 64'h0;
                    r_valid_d  = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - CNT_ONE;
                end
            end
            R_RESP: begin
                if (axi_R_READY) begin
                    r_valid_d  = 1'b0;
                    rd_state_d = R_IDLE;
                    ar_ready_d = !hold_off_s;
                end else begin
                    r_valid_d = 1'b1;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                r_valid_d  = 1'b0;
            end
        endcase
    end

    // Read FSM state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= CNT_ZERO;
            rd_addr_q  <= 64'h0;
            r_data_q   <= 64'h0;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            r_data_q   <= r_data_d;
            r_valid_q  <= r_valid_d;
            ar_ready_q <= ar_ready_d;
        end
    end

    assign axi_AR_READY = ar_ready_q;
    assign axi_R_VALID  = r_valid_q;
    assign axi_R_DATA   = r_data_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [AXI_AW-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_DW-1:0] wr_data_q, wr_data_d;
    logic [AXI_SW-1:0] wr_strb_q, wr_strb_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    logic              mem_we_s;

    logic [AXI_AW-1:0] wr_off_s;
    logic              wr_in_range_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              aw_acc_s, w_acc_s;
    logic              aw_have_s, w_have_s;

    assign wr_off_s      = wr_addr_q - BASE_ADDR;
    assign wr_in_range_s = (wr_addr_q >= BASE_ADDR) && (wr_off_s < MEM_BYTES);
    assign wr_idx_s      = wr_off_s[IDX_W+2:3];

    assign aw_acc_s  = axi_AW_VALID && aw_ready_q;
    assign w_acc_s   = axi_W_VALID && w_ready_q;
    assign aw_have_s = aw_held_q || aw_acc_s;
    assign w_have_s  = w_held_q || w_acc_s;

    // Write FSM next-state, registered outputs and memory commit strobe.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_ready_d = 1'b0;
        w_ready_d  = 1'b0;
        b_valid_d  = b_valid_q;
        mem_we_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_acc_s) begin
                    wr_addr_d = axi_AW_ADDR;
                end else begin
                    wr_addr_d = wr_addr_q;
                end
                if (w_acc_s) begin
                    wr_data_d = axi_W_DATA;
                    wr_strb_d = axi_W_STRB;
                end else begin
                    wr_data_d = wr_data_q;
                    wr_strb_d = wr_strb_q;
                end
                if (aw_have_s && w_have_s) begin
                    wr_state_d = W_WAIT;
                    wr_cnt_d   = CNT_W'(WR_LATENCY) + extra_s;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end else begin
                    aw_held_d  = aw_have_s;
                    w_held_d   = w_have_s;
                    aw_ready_d = !aw_have_s && !hold_off_s;
                    w_ready_d  = !w_have_s;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == CNT_ZERO) begin
                    mem_we_s   = wr_in_range_s;
                    b_valid_d  = 1'b1;
                    wr_state_d = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - CNT_ONE;
                end
            end
            W_RESP: begin
                if (axi_B_READY) begin
                    b_valid_d  = 1'b0;
                    wr_state_d = W_IDLE;
                    aw_ready_d = !hold_off_s;
                    w_ready_d  = 1'b1;
                end else begin
                    b_valid_d = 1'b1;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                b_valid_d  = 1'b0;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
            end
        endcase
    end

    // Write FSM state, latched request and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= CNT_ZERO;
            wr_addr_q  <= 64'h0;
            wr_data_q  <= 64'h0;
            wr_strb_q  <= 8'h00;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    assign axi_AW_READY = aw_ready_q;
    assign axi_W_READY  = w_ready_q;
    assign axi_B_VALID  = b_valid_q;

    axi_resp_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i     (clk),
        .rd_idx_i  (rd_idx_s),
        .rd_data_o (mem_rd_data_s),
        .we_i      (mem_we_s),
        .wr_idx_i  (wr_idx_s),
        .wr_data_i (wr_data_q),
        .wr_strb_i (wr_strb_q)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default parameters).
// With AXI_RESP_RAND_DELAY_EN defined, latency checks accept base+0..3 and a
// randomized scoreboard run is added.
module tb_axi_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int RD_BASE = 2;   // handshake edge to R_VALID edge, RD_LATENCY=1
    localparam int WR_BASE = 2;
`ifdef AXI_RESP_RAND_DELAY_EN
    localparam int XTRA = 3;
`else
    localparam int XTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] axi_AW_ADDR = 64'h0;
    logic        axi_AW_VALID = 1'b0;
    logic        axi_AW_READY;
    logic [63:0] axi_W_DATA = 64'h0;
    logic [7:0]  axi_W_STRB = 8'h00;
    logic        axi_W_VALID = 1'b0;
    logic        axi_W_READY;
    logic        axi_B_VALID;
    logic        axi_B_READY = 1'b0;
    logic [63:0] axi_AR_ADDR = 64'h0;
    logic        axi_AR_VALID = 1'b0;
    logic        axi_AR_READY;
    logic [63:0] axi_R_DATA;
    logic        axi_R_VALID;
    logic        axi_R_READY = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi_AW_ADDR  (axi_AW_ADDR),
        .axi_AW_VALID (axi_AW_VALID),
        .axi_AW_READY (axi_AW_READY),
        .axi_W_DATA   (axi_W_DATA),
        .axi_W_STRB   (axi_W_STRB),
        .axi_W_VALID  (axi_W_VALID),
        .axi_W_READY  (axi_W_READY),
        .axi_B_VALID  (axi_B_VALID),
        .axi_B_READY  (axi_B_READY),
        .axi_AR_ADDR  (axi_AR_ADDR),
        .axi_AR_VALID (axi_AR_VALID),
        .axi_AR_READY (axi_AR_READY),
        .axi_R_DATA   (axi_R_DATA),
        .axi_R_VALID  (axi_R_VALID),
        .axi_R_READY  (axi_R_READY)
    );

    // Bus driver: full read. Starts and ends at posedge+1. lat = -1 on timeout.
    task automatic read_txn(input logic [63:0] addr, output logic [63:0] data,
                            output int lat, output logic valid_after);
        int  n;
        logic hs, got;
        data = 64'h0; lat = -1; valid_after = 1'b1;
        axi_R_READY = 1'b1;
        axi_AR_ADDR = addr;
        axi_AR_VALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = axi_AR_READY;
            @(posedge clk); #1; n++;
        end
        axi_AR_VALID = 1'b0;
        if (!hs) return;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (axi_R_VALID) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        if (!got) return;
        data = axi_R_DATA;
        lat = n;
        @(posedge clk); #1;
        @(negedge clk); valid_after = axi_R_VALID;
        @(posedge clk); #1;
    endtask

    // Bus driver: full write. order 0 = AW and W together, 1 = AW first, 2 = W first.
    task automatic write_txn(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input int order,
                             output int lat, output logic valid_after);
        int  n, cyc;
        logic aw_done, w_done, hs_aw, hs_w, got;
        lat = -1; valid_after = 1'b1;
        axi_B_READY = 1'b1;
        axi_AW_ADDR = addr; axi_W_DATA = data; axi_W_STRB = strb;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            axi_AW_VALID = !aw_done && (order != 2 || cyc >= 1);
            axi_W_VALID  = !w_done  && (order != 1 || cyc >= 1);
            @(negedge clk);
            hs_aw = axi_AW_VALID && axi_AW_READY;
            hs_w  = axi_W_VALID && axi_W_READY;
            @(posedge clk); #1;
            if (hs_aw) aw_done = 1'b1;
            if (hs_w)  w_done = 1'b1;
            cyc++;
        end
        axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
        if (!(aw_done && w_done)) return;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (axi_B_VALID) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        if (!got) return;
        lat = n;
        @(posedge clk); #1;
        @(negedge clk); valid_after = axi_B_VALID;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (axi_AR_READY !== 1'b0) begin errors++; $display("FAIL rst_ar_ready: got %b want 0", axi_AR_READY); end
        checks++; if (axi_AW_READY !== 1'b0) begin errors++; $display("FAIL rst_aw_ready: got %b want 0", axi_AW_READY); end
        checks++; if (axi_W_READY !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %b want 0", axi_W_READY); end
        checks++; if (axi_R_VALID !== 1'b0) begin errors++; $display("FAIL rst_r_valid: got %b want 0", axi_R_VALID); end
        checks++; if (axi_B_VALID !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b want 0", axi_B_VALID); end
        checks++; if (axi_R_DATA !== 64'h0) begin errors++; $display("FAIL rst_r_data: got %h want 0", axi_R_DATA); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (axi_W_READY !== 1'b1) begin errors++; $display("FAIL idle_w_ready: got %b want 1", axi_W_READY); end
`ifndef AXI_RESP_RAND_DELAY_EN
        checks++; if (axi_AR_READY !== 1'b1) begin errors++; $display("FAIL idle_ar_ready: got %b want 1", axi_AR_READY); end
        checks++; if (axi_AW_READY !== 1'b1) begin errors++; $display("FAIL idle_aw_ready: got %b want 1", axi_AW_READY); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        logic [63:0] d; int lat; logic va;
        write_txn(BASE, 64'h1122334455667788, 8'hFF, 0, lat, va);
        checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL wr0_lat: got %0d want %0d..%0d", lat, WR_BASE, WR_BASE + XTRA); end
        read_txn(BASE, d, lat, va);
        checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL rd0_data: got %h want 1122334455667788", d); end
        checks++; if (lat < RD_BASE || lat > RD_BASE + XTRA) begin errors++; $display("FAIL rd0_lat: got %0d want %0d..%0d", lat, RD_BASE, RD_BASE + XTRA); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL rd0_pulse: r_valid after hs %b want 0", va); end
        // Low address bits are ignored.
        read_txn(BASE + 64'h4, d, lat, va);
        checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL rd_unaligned: got %h want 1122334455667788", d); end
    endtask

    task automatic test_write_strobe();
        logic [63:0] d; int lat; logic va;
        write_txn(BASE + 64'h8, 64'h0, 8'hFF, 0, lat, va);
        write_txn(BASE + 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1, lat, va);
        checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL wr_strb_lat: got %0d want %0d..%0d", lat, WR_BASE, WR_BASE + XTRA); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL wr_b_pulse: b_valid after hs %b want 0", va); end
        read_txn(BASE + 64'h8, d, lat, va);
        checks++; if (d !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wr_strb_data: got %h want 00000000ffffffff", d); end
        write_txn(BASE + 64'h8, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 0, lat, va);
        checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL wr_strb0_lat: got %0d", lat); end
        read_txn(BASE + 64'h8, d, lat, va);
        checks++; if (d !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL wr_strb0_data: got %h want 00000000ffffffff", d); end
        write_txn(BASE + 64'h8, 64'hA1B2_C3D4_E5F6_0718, 8'hA5, 2, lat, va);
        read_txn(BASE + 64'h8, d, lat, va);
        checks++; if (d !== 64'hA100_C300_FFF6_FF18) begin errors++; $display("FAIL wr_strbA5_data: got %h want a100c300fff6ff18", d); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] d; int lat; logic va;
        write_txn(64'h7FFF_FFF8, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 2, lat, va);
        checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL oor_lo_b: lat %0d want %0d..%0d", lat, WR_BASE, WR_BASE + XTRA); end
        read_txn(64'h7FFF_FFF8, d, lat, va);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL oor_lo_rdata: got %h want 0", d); end
        checks++; if (lat < RD_BASE || lat > RD_BASE + XTRA) begin errors++; $display("FAIL oor_lo_rlat: got %0d", lat); end
        // First address past the end would alias word 0 if range were not checked.
        write_txn(BASE + 64'h8000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 0, lat, va);
        checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL oor_hi_b: lat %0d", lat); end
        read_txn(BASE + 64'h8000, d, lat, va);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL oor_hi_rdata: got %h want 0", d); end
        read_txn(BASE, d, lat, va);
        checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL oor_no_alias: word0 %h want 1122334455667788", d); end
        write_txn(BASE + 64'h7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, lat, va);
        read_txn(BASE + 64'h7FF8, d, lat, va);
        checks++; if (d !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL last_word: got %h want 0123456789abcdef", d); end
    endtask

    task automatic test_backpressure();
        int n; logic hs, got; logic [63:0] d0;
        // Read side with R_READY low.
        axi_R_READY = 1'b0;
        axi_AR_ADDR = BASE; axi_AR_VALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin @(negedge clk); hs = axi_AR_READY; @(posedge clk); #1; n++; end
        axi_AR_VALID = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); if (axi_R_VALID) got = 1'b1; else begin @(posedge clk); #1; n++; end end
        checks++; if (!got) begin errors++; $display("FAIL bp_r_timeout: r_valid %b want 1", axi_R_VALID); end
        d0 = axi_R_DATA;
        checks++; if (d0 !== 64'h1122334455667788) begin errors++; $display("FAIL bp_r_data: got %h want 1122334455667788", d0); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; @(negedge clk);
            checks++;
            if (axi_R_VALID !== 1'b1 || axi_R_DATA !== d0 || axi_AR_READY !== 1'b0) begin
                errors++; $display("FAIL bp_r_hold%0d: valid %b data %h ar_ready %b want 1 %h 0", i, axi_R_VALID, axi_R_DATA, axi_AR_READY, d0);
            end
        end
        @(posedge clk); #1; axi_R_READY = 1'b1;
        @(posedge clk); #1; @(negedge clk);
        checks++; if (axi_R_VALID !== 1'b0) begin errors++; $display("FAIL bp_r_release: r_valid %b want 0", axi_R_VALID); end
`ifndef AXI_RESP_RAND_DELAY_EN
        checks++; if (axi_AR_READY !== 1'b1) begin errors++; $display("FAIL bp_ar_return: ar_ready %b want 1", axi_AR_READY); end
`endif
        @(posedge clk); #1;
        // Write side with B_READY low.
        axi_B_READY = 1'b0;
        axi_AW_ADDR = BASE + 64'h10; axi_W_DATA = 64'h7777_8888_9999_AAAA; axi_W_STRB = 8'hFF;
        axi_AW_VALID = 1'b1; axi_W_VALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = axi_AW_READY && axi_W_READY;
            @(posedge clk); #1; n++;
        end
        axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); if (axi_B_VALID) got = 1'b1; else begin @(posedge clk); #1; n++; end end
        checks++; if (!got) begin errors++; $display("FAIL bp_b_timeout: b_valid %b want 1", axi_B_VALID); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; @(negedge clk);
            checks++;
            if (axi_B_VALID !== 1'b1 || axi_AW_READY !== 1'b0 || axi_W_READY !== 1'b0) begin
                errors++; $display("FAIL bp_b_hold%0d: b_valid %b aw_ready %b w_ready %b want 1 0 0", i, axi_B_VALID, axi_AW_READY, axi_W_READY);
            end
        end
        @(posedge clk); #1; axi_B_READY = 1'b1;
        @(posedge clk); #1; @(negedge clk);
        checks++; if (axi_B_VALID !== 1'b0) begin errors++; $display("FAIL bp_b_release: b_valid %b want 0", axi_B_VALID); end
        checks++; if (axi_W_READY !== 1'b1) begin errors++; $display("FAIL bp_w_return: w_ready %b want 1", axi_W_READY); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int n; logic hs, seen; logic [63:0] d; int lat; logic va;
        axi_R_READY = 1'b1;
        axi_AR_ADDR = BASE; axi_AR_VALID = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 50) begin @(negedge clk); hs = axi_AR_READY; @(posedge clk); #1; n++; end
        axi_AR_VALID = 1'b0;
        // FSM is now in R_WAIT; drop it with reset before the capture edge.
        rst_n = 1'b0;
        @(posedge clk); #1; @(negedge clk);
        checks++; if (axi_AR_READY !== 1'b0 || axi_R_VALID !== 1'b0) begin errors++; $display("FAIL midrst_outputs: ar_ready %b r_valid %b want 0 0", axi_AR_READY, axi_R_VALID); end
        @(posedge clk); #1; rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if (axi_R_VALID) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_r: r_valid seen %b want 0", seen); end
        read_txn(BASE, d, lat, va);
        checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL midrst_next_rd: got %h want 1122334455667788", d); end
        checks++; if (lat < RD_BASE || lat > RD_BASE + XTRA) begin errors++; $display("FAIL midrst_next_lat: got %0d", lat); end
    endtask

    task automatic test_same_cycle();
        int n; logic rdy, got; logic [63:0] d; int lat; logic va;
        write_txn(BASE + 64'h18, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, 0, lat, va);
        axi_R_READY = 1'b1; axi_B_READY = 1'b1;
        axi_AR_ADDR = BASE + 64'h18; axi_AW_ADDR = BASE + 64'h18;
        axi_W_DATA = 64'h5555_5555_5555_5555; axi_W_STRB = 8'hFF;
        axi_AR_VALID = 1'b1; axi_AW_VALID = 1'b1; axi_W_VALID = 1'b1;
        @(negedge clk); rdy = axi_AR_READY && axi_AW_READY && axi_W_READY;
        @(posedge clk); #1;
        axi_AR_VALID = 1'b0; axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL same_ready: all ready %b want 1", rdy); end
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); if (axi_R_VALID) got = 1'b1; else begin @(posedge clk); #1; n++; end end
        checks++; if (axi_R_DATA !== 64'h0A0A_0A0A_0A0A_0A0A) begin errors++; $display("FAIL same_prewrite: got %h want 0a0a0a0a0a0a0a0a", axi_R_DATA); end
        checks++; if (axi_B_VALID !== 1'b1) begin errors++; $display("FAIL same_b_align: b_valid %b want 1", axi_B_VALID); end
        @(posedge clk); #1; @(posedge clk); #1;
        read_txn(BASE + 64'h18, d, lat, va);
        checks++; if (d !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL same_postwrite: got %h want 5555555555555555", d); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; int lat; logic va;
        logic [63:0] vals [4];
        vals[0] = 64'h1000_0000_0000_0001; vals[1] = 64'h2000_0000_0000_0002;
        vals[2] = 64'h3000_0000_0000_0003; vals[3] = 64'h4000_0000_0000_0004;
        for (int i = 0; i < 4; i++) begin
            write_txn(BASE + 64'h40 + 64'(i) * 64'h8, vals[i], 8'hFF, i % 3, lat, va);
            checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL b2b_wlat%0d: got %0d", i, lat); end
        end
        for (int i = 0; i < 4; i++) begin
            read_txn(BASE + 64'h40 + 64'(i) * 64'h8, d, lat, va);
            checks++; if (d !== vals[i]) begin errors++; $display("FAIL b2b_rdata%0d: got %h want %h", i, d, vals[i]); end
        end
    endtask

`ifdef AXI_RESP_RAND_DELAY_EN
    task automatic test_random();
        logic [63:0] model [16];
        logic [63:0] d, wd; logic [7:0] st; int lat, idx; logic va;
        for (int i = 0; i < 16; i++) begin
            write_txn(BASE + 64'h100 + 64'(i) * 64'h8, 64'h0, 8'hFF, 0, lat, va);
            model[i] = 64'h0;
        end
        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                wd = {$urandom(), $urandom()}; st = 8'($urandom_range(0, 255));
                write_txn(BASE + 64'h100 + 64'(idx) * 64'h8 + 64'($urandom_range(0, 7)), wd, st,
                          $urandom_range(0, 2), lat, va);
                for (int b = 0; b < 8; b++) if (st[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                checks++; if (lat < WR_BASE || lat > WR_BASE + XTRA) begin errors++; $display("FAIL rnd_wlat t%0d: got %0d", t, lat); end
            end else begin
                read_txn(BASE + 64'h100 + 64'(idx) * 64'h8, d, lat, va);
                checks++; if (d !== model[idx]) begin errors++; $display("FAIL rnd_rdata t%0d: got %h want %h", t, d, model[idx]); end
                checks++; if (lat < RD_BASE || lat > RD_BASE + XTRA) begin errors++; $display("FAIL rnd_rlat t%0d: got %0d", t, lat); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_basic();
        test_write_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_midflight();
`ifndef AXI_RESP_RAND_DELAY_EN
        test_same_cycle();
`endif
        test_back_to_back();
`ifdef AXI_RESP_RAND_DELAY_EN
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
